// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/lap controller.
// Conditions the button and divider inputs, derives the centisecond tick from
// the 200 Hz divider square wave, sequences the MM:SS.cc BCD counter chain
// through an IDLE/RUN/LAP/PAUSE state machine, and freezes the display while
// a lap time is being shown.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 2,
  parameter int MAX_MIN  = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_frq,
  input  logic        btn_ss,
  input  logic        btn_lap,
  input  logic        btn_clr,
  output logic        div_rst,
  output logic [23:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        wrapped
);

  // Prescaler terminal count and the minute value at which the chain wraps.
  localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);
  localparam logic [3:0] MAX_MIN_T  = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MIN_O  = 4'(MAX_MIN % 10);

  // Bit positions of the conditioned inputs inside the synchroniser vectors.
  localparam int IN_SS  = 0;
  localparam int IN_LAP = 1;
  localparam int IN_CLR = 2;
  localparam int IN_FRQ = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  // Input conditioning: two synchroniser stages plus previous-value register.
  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [3:0]  prev_q,  prev_d;
  logic [3:0]  ev;

  // Control and datapath state.
  state_t      state_q, state_d;
  logic [7:0]  presc_q, presc_d;
  logic [23:0] cnt_q,   cnt_d;
  logic [23:0] lap_q,   lap_d;
  logic        wrapped_q, wrapped_d;
  logic        cs_tick;
  logic [24:0] inc;

  // Registered outputs.
  logic [23:0] disp_q, disp_d;
  logic        div_rst_q, div_rst_d;
  logic        running_q, running_d;
  logic        lap_active_q, lap_active_d;

  // Advance a packed {min_t, min_o, sec_t, sec_o, cs_t, cs_o} BCD time by one
  // centisecond. Bit 24 of the result flags the MAX_MIN:59.99 -> 00:00.00 wrap.
  function automatic logic [24:0] time_inc(input logic [23:0] t);
    logic [23:0] n;
    logic        w;
    n = t;
    w = 1'b0;
    if (t[3:0] != 4'd9) begin
      n[3:0] = t[3:0] + 4'd1;
    end else begin
      n[3:0] = 4'd0;
      if (t[7:4] != 4'd9) begin
        n[7:4] = t[7:4] + 4'd1;
      end else begin
        n[7:4] = 4'd0;
        if (t[11:8] != 4'd9) begin
          n[11:8] = t[11:8] + 4'd1;
        end else begin
          n[11:8] = 4'd0;
          if (t[15:12] != 4'd5) begin
            n[15:12] = t[15:12] + 4'd1;
          end else begin
            n[15:12] = 4'd0;
            if (t[23:16] == {MAX_MIN_T, MAX_MIN_O}) begin
              n[23:16] = 8'd0;
              w        = 1'b1;
            end else if (t[19:16] != 4'd9) begin
              n[19:16] = t[19:16] + 4'd1;
            end else begin
              n[19:16] = 4'd0;
              n[23:20] = t[23:20] + 4'd1;
            end
          end
        end
      end
    end
    return {w, n};
  endfunction

  assign inc = time_inc(cnt_q);

  // Synchronise the asynchronous inputs and turn each rising edge into a one-cycle pulse.
  always_comb begin
    sync1_d = {clk_frq, btn_clr, btn_lap, btn_ss};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    ev      = sync2_q & ~prev_q;
  end

  // Next-state logic: prescaler, counter chain, lap latch and the button-driven FSM.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    lap_d     = lap_q;
    wrapped_d = wrapped_q;
    cs_tick   = 1'b0;

    // The prescaler only advances while counting; it keeps its phase in PAUSE
    // and restarts from zero once the stopwatch is back in IDLE.
    if (state_q == S_IDLE) begin
      presc_d = 8'd0;
    end else if ((state_q == S_RUN || state_q == S_LAP) && ev[IN_FRQ]) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = 8'd0;
        cs_tick = 1'b1;
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end

    // A tick coinciding with a stop press still lands, so the paused value includes it.
    if (cs_tick) begin
      cnt_d = inc[23:0];
      if (inc[24]) begin
        wrapped_d = 1'b1;
      end
    end

    // Button events resolve with clear over start/stop over lap.
    case (state_q)
      S_IDLE: begin
        if (ev[IN_SS]) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (ev[IN_SS]) begin
          state_d = S_PAUSE;
        end else if (ev[IN_LAP]) begin
          state_d = S_LAP;
          lap_d   = cnt_d;
        end
      end
      S_LAP: begin
        if (ev[IN_SS]) begin
          state_d = S_PAUSE;
        end else if (ev[IN_LAP]) begin
          state_d = S_RUN;
        end
      end
      S_PAUSE: begin
        if (ev[IN_CLR]) begin
          state_d   = S_IDLE;
          cnt_d     = 24'd0;
          presc_d   = 8'd0;
          wrapped_d = 1'b0;
        end else if (ev[IN_SS]) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: status flags follow the next state, the display follows the current source.
  always_comb begin
    div_rst_d    = (state_d == S_IDLE);
    running_d    = (state_d == S_RUN) || (state_d == S_LAP);
    lap_active_d = (state_d == S_LAP);
    disp_d       = (state_q == S_LAP) ? lap_q : cnt_q;
  end

  // All state and output registers; reset puts the divider in reset and clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 4'd0;
      sync2_q      <= 4'd0;
      prev_q       <= 4'd0;
      state_q      <= S_IDLE;
      presc_q      <= 8'd0;
      cnt_q        <= 24'd0;
      lap_q        <= 24'd0;
      wrapped_q    <= 1'b0;
      disp_q       <= 24'd0;
      div_rst_q    <= 1'b1;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      state_q      <= state_d;
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      lap_q        <= lap_d;
      wrapped_q    <= wrapped_d;
      disp_q       <= disp_d;
      div_rst_q    <= div_rst_d;
      running_q    <= running_d;
      lap_active_q <= lap_active_d;
    end
  end

  assign div_rst    = div_rst_q;
  assign disp_bcd   = disp_q;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign wrapped    = wrapped_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: directed scenarios plus a randomized button /
// divider sequence, all compared against a centisecond-level reference model.
module tb_stopwatch_ctrl;

  localparam int TD   = 2;
  localparam int MM   = 59;
  localparam int W_TD = 1;
  localparam int W_MM = 1;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_LAP   = 2;
  localparam int M_PAUSE = 3;

  localparam logic [27:0] RST_VEC = {24'h000000, 1'b0, 1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frq = 1'b0, ss = 1'b0, lap = 1'b0, clr = 1'b0;
  logic w_frq = 1'b0, w_ss = 1'b0, w_lap = 1'b0, w_clr = 1'b0;

  logic        div_rst, running, lap_active, wrapped;
  logic [23:0] disp_bcd;
  logic        w_div_rst, w_running, w_lap_active, w_wrapped;
  logic [23:0] w_disp_bcd;

  logic [27:0] obs;
  logic [27:0] w_obs;
  assign obs   = {disp_bcd, running, lap_active, div_rst, wrapped};
  assign w_obs = {w_disp_bcd, w_running, w_lap_active, w_div_rst, w_wrapped};

  int checks = 0;
  int errors = 0;

  // Reference model state (main instance).
  int m_mode, m_cs, m_presc, m_lap;
  bit m_wrapped;

  stopwatch_ctrl #(.TICK_DIV(TD), .MAX_MIN(MM)) dut (
    .clk(clk), .rst(rst), .clk_frq(frq),
    .btn_ss(ss), .btn_lap(lap), .btn_clr(clr),
    .div_rst(div_rst), .disp_bcd(disp_bcd), .running(running),
    .lap_active(lap_active), .wrapped(wrapped)
  );

  stopwatch_ctrl #(.TICK_DIV(W_TD), .MAX_MIN(W_MM)) dut_wrap (
    .clk(clk), .rst(rst), .clk_frq(w_frq),
    .btn_ss(w_ss), .btn_lap(w_lap), .btn_clr(w_clr),
    .div_rst(w_div_rst), .disp_bcd(w_disp_bcd), .running(w_running),
    .lap_active(w_lap_active), .wrapped(w_wrapped)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int cs, input int maxmin);
    int t, m, s, c;
    t = cs % ((maxmin + 1) * 6000);
    m = t / 6000;
    s = (t / 100) % 60;
    c = t % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [27:0] exp_vec();
    return {to_bcd((m_mode == M_LAP) ? m_lap : m_cs, MM),
            (m_mode == M_RUN || m_mode == M_LAP), (m_mode == M_LAP),
            (m_mode == M_IDLE), m_wrapped};
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE; m_cs = 0; m_presc = 0; m_lap = 0; m_wrapped = 1'b0;
  endfunction

  function automatic void model_frq(input int n);
    for (int i = 0; i < n; i++) begin
      if (m_mode == M_RUN || m_mode == M_LAP) begin
        m_presc++;
        if (m_presc == TD) begin
          m_presc = 0;
          m_cs++;
          if (m_cs % ((MM + 1) * 6000) == 0) m_wrapped = 1'b1;
        end
      end
    end
  endfunction

  // which: 0 start/stop, 1 lap, 2 clear
  function automatic void model_press(input int which);
    case (which)
      0: begin
        if (m_mode == M_IDLE || m_mode == M_PAUSE) m_mode = M_RUN;
        else m_mode = M_PAUSE;
      end
      1: begin
        if (m_mode == M_RUN) begin m_mode = M_LAP; m_lap = m_cs; end
        else if (m_mode == M_LAP) m_mode = M_RUN;
      end
      2: begin
        if (m_mode == M_PAUSE) begin
          m_mode = M_IDLE; m_cs = 0; m_presc = 0; m_wrapped = 1'b0;
        end
      end
      default: ;
    endcase
  endfunction

  // which: 0..2 main ss/lap/clr, 3 wrap-instance ss, 4 wrap-instance clr
  task automatic press(input int which, input int hold);
    case (which)
      0: ss = 1'b1;
      1: lap = 1'b1;
      2: clr = 1'b1;
      3: w_ss = 1'b1;
      default: w_clr = 1'b1;
    endcase
    repeat (hold) @(negedge clk);
    ss = 1'b0; lap = 1'b0; clr = 1'b0; w_ss = 1'b0; w_clr = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frq_edges(input int n, input int half, input bit wr);
    repeat (n) begin
      if (wr) w_frq = 1'b1; else frq = 1'b1;
      repeat (half) @(negedge clk);
      frq = 1'b0; w_frq = 1'b0;
      repeat (half) @(negedge clk);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== RST_VEC) begin errors++; $display("FAIL reset_idle: got %h expected %h", obs, RST_VEC); end
    frq_edges(5, 2, 1'b0);
    model_frq(5);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL idle_no_count: got %h expected %h", obs, exp_vec()); end
    press(0, 3); model_press(0);
    frq_edges(37, 2, 1'b0); model_frq(37);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL pre_reset_count: got %h expected %h", obs, exp_vec()); end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++;
    if (obs !== RST_VEC) begin errors++; $display("FAIL async_reset: got %h expected %h", obs, RST_VEC); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL reset_release: got %h expected %h", obs, exp_vec()); end
  endtask

  task automatic test_count_latency();
    do_reset();
    ss = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({running, div_rst} !== 2'b01) begin errors++; $display("FAIL latency_early: got %b expected %b", {running, div_rst}, 2'b01); end
    @(posedge clk); #1;
    checks++;
    if ({running, div_rst} !== 2'b10) begin errors++; $display("FAIL latency_start: got %b expected %b", {running, div_rst}, 2'b10); end
    @(negedge clk);
    ss = 1'b0;
    repeat (6) @(negedge clk);
    model_press(0);
    frq_edges(250, 2, 1'b0); model_frq(250);
    checks++;
    if (disp_bcd !== 24'h000125) begin errors++; $display("FAIL count_125: got %h expected %h", disp_bcd, 24'h000125); end
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL count_model: got %h expected %h", obs, exp_vec()); end
  endtask

  task automatic test_lap();
    press(1, 4); model_press(1);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL lap_enter: got %h expected %h", obs, exp_vec()); end
    frq_edges(100, 2, 1'b0); model_frq(100);
    checks++;
    if ({disp_bcd, lap_active} !== {24'h000125, 1'b1}) begin
      errors++; $display("FAIL lap_frozen: got %h expected %h", {disp_bcd, lap_active}, {24'h000125, 1'b1});
    end
    press(1, 2); model_press(1);
    checks++;
    if ({disp_bcd, lap_active} !== {24'h000175, 1'b0}) begin
      errors++; $display("FAIL lap_release: got %h expected %h", {disp_bcd, lap_active}, {24'h000175, 1'b0});
    end
  endtask

  task automatic test_pause_clear();
    do_reset();
    press(0, 2); model_press(0);
    frq_edges(80, 2, 1'b0); model_frq(80);
    press(0, 5); model_press(0);
    checks++;
    if ({disp_bcd, running} !== {24'h000040, 1'b0}) begin
      errors++; $display("FAIL pause_enter: got %h expected %h", {disp_bcd, running}, {24'h000040, 1'b0});
    end
    frq_edges(50, 2, 1'b0); model_frq(50);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL pause_hold: got %h expected %h", obs, exp_vec()); end
    press(2, 3); model_press(2);
    checks++;
    if ({disp_bcd, div_rst} !== {24'h000000, 1'b1}) begin
      errors++; $display("FAIL pause_clear: got %h expected %h", {disp_bcd, div_rst}, {24'h000000, 1'b1});
    end
    press(0, 2); model_press(0);
    frq_edges(30, 2, 1'b0); model_frq(30);
    press(2, 3); model_press(2);
    frq_edges(30, 2, 1'b0); model_frq(30);
    checks++;
    if ({disp_bcd, running} !== {24'h000030, 1'b1}) begin
      errors++; $display("FAIL clr_in_run: got %h expected %h", {disp_bcd, running}, {24'h000030, 1'b1});
    end
  endtask

  task automatic test_priority();
    do_reset();
    press(0, 2); model_press(0);
    frq_edges(20, 2, 1'b0); model_frq(20);
    ss = 1'b1; lap = 1'b1;
    repeat (3) @(negedge clk);
    ss = 1'b0; lap = 1'b0;
    repeat (6) @(negedge clk);
    model_press(0);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL prio_ss_lap: got %h expected %h", obs, exp_vec()); end
    frq_edges(10, 2, 1'b0); model_frq(10);
    checks++;
    if ({disp_bcd, lap_active} !== {24'h000010, 1'b0}) begin
      errors++; $display("FAIL prio_no_latch: got %h expected %h", {disp_bcd, lap_active}, {24'h000010, 1'b0});
    end
    ss = 1'b1; clr = 1'b1;
    repeat (3) @(negedge clk);
    ss = 1'b0; clr = 1'b0;
    repeat (6) @(negedge clk);
    model_press(2);
    checks++;
    if (obs !== RST_VEC) begin errors++; $display("FAIL prio_clr_ss: got %h expected %h", obs, RST_VEC); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    press(0, 2); model_press(0);
    frq_edges(3, 2, 1'b0); model_frq(3);
    // tick and stop land on the same cycle
    frq = 1'b1; ss = 1'b1;
    repeat (2) @(negedge clk);
    frq = 1'b0; ss = 1'b0;
    repeat (6) @(negedge clk);
    model_frq(1); model_press(0);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL tick_with_stop: got %h expected %h", obs, exp_vec()); end
    // restart on the same cycle as a divider edge: the edge is lost
    frq = 1'b1; ss = 1'b1;
    repeat (2) @(negedge clk);
    frq = 1'b0; ss = 1'b0;
    repeat (6) @(negedge clk);
    model_press(0);
    frq_edges(1, 2, 1'b0); model_frq(1);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL edge_with_start: got %h expected %h", obs, exp_vec()); end
    frq_edges(1, 2, 1'b0); model_frq(1);
    checks++;
    if (disp_bcd !== 24'h000003) begin errors++; $display("FAIL edge_after_start: got %h expected %h", disp_bcd, 24'h000003); end
  endtask

  task automatic test_random();
    int op, n;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 1) begin
        press(0, $urandom_range(1, 8)); model_press(0);
      end else if (op == 2) begin
        press(1, $urandom_range(1, 8)); model_press(1);
      end else if (op == 3) begin
        press(2, $urandom_range(1, 8)); model_press(2);
      end else begin
        n = $urandom_range(1, 300);
        frq_edges(n, $urandom_range(1, 3), 1'b0); model_frq(n);
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random_step%0d op%0d: got %h expected %h", i, op, obs, exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    press(3, 2);
    frq_edges(11999, 1, 1'b1);
    checks++;
    if ({w_disp_bcd, w_wrapped} !== {to_bcd(11999, W_MM), 1'b0} || w_disp_bcd !== 24'h015999) begin
      errors++; $display("FAIL wrap_last: got %h expected %h", {w_disp_bcd, w_wrapped}, {24'h015999, 1'b0});
    end
    frq_edges(1, 1, 1'b1);
    checks++;
    if ({w_disp_bcd, w_wrapped} !== {24'h000000, 1'b1}) begin
      errors++; $display("FAIL wrap_roll: got %h expected %h", {w_disp_bcd, w_wrapped}, {24'h000000, 1'b1});
    end
    frq_edges(5, 1, 1'b1);
    checks++;
    if ({w_disp_bcd, w_wrapped} !== {24'h000005, 1'b1}) begin
      errors++; $display("FAIL wrap_sticky: got %h expected %h", {w_disp_bcd, w_wrapped}, {24'h000005, 1'b1});
    end
    press(3, 2);
    checks++;
    if ({w_running, w_wrapped} !== 2'b01) begin
      errors++; $display("FAIL wrap_pause: got %b expected %b", {w_running, w_wrapped}, 2'b01);
    end
    press(4, 2);
    checks++;
    if (w_obs !== RST_VEC) begin errors++; $display("FAIL wrap_clear: got %h expected %h", w_obs, RST_VEC); end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_count_latency();
    test_lap();
    test_pause_clear();
    test_priority();
    test_back_to_back();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Run/stop/lap controller for the stopwatch. Consumes the 200 Hz square wave from the clock divider and divides it by 2 internally to get a 100 Hz centisecond tick.
- Sequences the BCD time counters (MM:SS.cc) through a 4-state FSM driven by three button inputs, and freezes the display for lap capture.
- Drives the divider's reset so every fresh run starts on a clean divider phase.
- Sits between the divider, the button debouncers and the FND display mux.

Parameters:
TICK_DIV, 2, number of clk_frq rising edges per centisecond increment (range 1..255)
MAX_MIN, 59, minute value at which the count wraps to 00:00.00

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
clk_frq  in  1  divider square-wave output; asynchronous to logic phase, synchronised internally
btn_ss  in  1  start/stop button level, debounced, not synchronised
btn_lap  in  1  lap button level
btn_clr  in  1  clear button level
div_rst  out  1  active-high reset to the divider; registered
disp_bcd  out  24  {min_t, min_o, sec_t, sec_o, cs_t, cs_o}, 4-bit BCD each
running  out  1  1 in RUN or LAP
lap_active  out  1  1 in LAP (display frozen)
wrapped  out  1  sticky: set on MAX_MIN:59.99 -> 00:00.00 rollover

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all live counters, lap latch and disp_bcd = 0.
  - div_rst=1; running=0; lap_active=0; wrapped=0.
  - Synchronisers, edge registers and prescaler cleared.
  - Release is synchronous to clk; the first active edge after release evaluates normally.
- Input conditioning (btn_ss, btn_lap, btn_clr, clk_frq):
  - Each input passes through a 2-FF synchroniser, then a previous-value register.
  - Event pulse = sync2 & ~prev (one cycle per rising edge).
  - Input high first sampled at edge k -> pulse valid in the cycle after edge k+1 -> state/counter effect visible after edge k+2.
- Tick generation:
  - Prescaler counts clk_frq edge pulses while state is RUN or LAP.
  - At TICK_DIV-1 the prescaler wraps to 0 and issues cs_tick (same cycle as the edge pulse).
  - Prescaler holds its value in PAUSE and is cleared in IDLE.
- Counter chain (BCD; each digit 0..9, tens of seconds 0..5):
  - cs 00..99 -> sec 00..59 -> min 00..MAX_MIN.
  - 99 cs plus tick -> cs=00 and sec+1; 59 s plus carry -> sec=00 and min+1.
  - MAX_MIN:59.99 plus tick -> 00:00.00 and wrapped<=1; the counters keep running.
- FSM (events evaluated with priority clr > ss > lap; lower-priority events in the same cycle are dropped):
  - IDLE: ss -> RUN. lap and clr ignored. div_rst=1 in IDLE, 0 in every other state.
  - RUN: ss -> PAUSE. lap -> LAP, latching the live counters (including any same-cycle increment) into the lap latch. clr ignored.
  - LAP: counting continues; disp_bcd shows the lap latch. lap -> RUN (display live). ss -> PAUSE (display live). clr ignored.
  - PAUSE: ss -> RUN. clr -> IDLE, zeroing counters, prescaler and wrapped. lap ignored.
- Outputs:
  - disp_bcd is registered: live counters in IDLE, RUN and PAUSE; lap latch in LAP. Updated one cycle after the source changes.
  - running and lap_active are decoded from registered state.
- Simultaneous cs_tick and state-leaving event:
  - RUN/LAP -> PAUSE: the tick is applied and the paused value includes it.
  - PAUSE -> RUN on the same cycle as a clk_frq edge: the edge does not count.
- Holding a button produces exactly one event; release produces none.

Test Plan:
- Reset: rst=0 mid-RUN with a nonzero count -> asynchronously disp_bcd=24'h000000, div_rst=1, running=0, wrapped=0.
- Count and latency: ss pulse, then 250 clk_frq periods (TICK_DIV=2) -> disp_bcd=24'h000125. running=1 exactly 2 clk edges after btn_ss first sampled high; div_rst=0 from the same edge.
- Lap freeze: at 00:01.25 press lap, apply 100 more clk_frq periods -> disp_bcd stays 24'h000125 with lap_active=1. Press lap again -> disp_bcd=24'h000175.
- Pause/clear: ss at 00:00.40 -> PAUSE. 50 more clk_frq periods -> display stays 00:00.40. clr -> 000000 with div_rst=1. clr while in RUN -> ignored, counting continues.
- Wrap: force count to 59:59.99 (MAX_MIN=59), apply 2 clk_frq edges -> disp_bcd=24'h000000, wrapped=1 and held until clr in PAUSE.
- Priority: btn_ss and btn_lap rise on the same clk in RUN -> PAUSE entered and no lap latch taken. btn_clr and btn_ss together in PAUSE -> IDLE.
